xor_fold_hasher: RTL and testbench

Iterative, parametrised XOR-fold hash engine for the hash controller. It reduces a DIN_W-bit lookup key (e.g. MAC + VLAN) to a DOUT_W-bit table index. Keys arrive over a valid/ready stream and are folded SLICES_PER_CYC slices per clock, with an optional seed and a rotate-XOR mode. It sits between the header extractor and the MAC table address logic.

---
 rtl/hash_pkg.sv | 38 +++
 rtl/xor_fold_step.sv | 25 ++
 rtl/xor_fold_hasher.sv | 120 ++++++++++++
 tb/tb_xor_fold_hasher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared types and helpers for the XOR-fold hash engine.
// rotl works on a fixed-width container so one definition serves every DOUT_W.
package hash_pkg;

  localparam int unsigned HASH_MAX_W = 64;
  localparam int unsigned HASH_IDX_W = $clog2(HASH_MAX_W);

  typedef enum logic {
    HASH_XOR    = 1'b0,
    HASH_ROTXOR = 1'b1
  } hash_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } hasher_state_e;

  function automatic int unsigned n_slices(input int unsigned din_w,
                                           input int unsigned dout_w);
    return (din_w + dout_w - 1) / dout_w;
  endfunction

  // Left-rotate the low 'width' bits of value by 'amount'; upper bits return zero.
  function automatic logic [HASH_MAX_W-1:0] rotl(input logic [HASH_MAX_W-1:0] value,
                                                 input int unsigned           amount,
                                                 input int unsigned           width);
    logic [HASH_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < HASH_MAX_W; i++) begin
      if (i < width) begin
        r[HASH_IDX_W'((i + amount) % width)] = value[HASH_IDX_W'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_fold_step.sv
// One fold step: acc' = (mode ? rotl(acc, ROT) : acc) ^ slice, or pass-through when disabled.
module xor_fold_step
  import hash_pkg::*;
#(
  parameter int unsigned DOUT_W = 12,
  parameter int unsigned ROT    = 1
) (
  input  logic [DOUT_W-1:0] acc,
  input  logic [DOUT_W-1:0] slice,
  input  logic              mode,
  input  logic              enable,
  output logic [DOUT_W-1:0] next_acc
);

  logic [DOUT_W-1:0] rotated;

  always_comb begin
    rotated  = DOUT_W'(rotl(HASH_MAX_W'(acc), ROT, DOUT_W));
    next_acc = acc;
    if (enable) begin
      next_acc = ((mode == HASH_ROTXOR) ? rotated : acc) ^ slice;
    end
  end

endmodule

// File: rtl/xor_fold_hasher.sv
// Iterative XOR-fold hash: reduces a DIN_W-bit key to DOUT_W bits, SLICES_PER_CYC slices per clock.
// Valid/ready on both sides; the result is held in DONE until the sink accepts it.
module xor_fold_hasher
  import hash_pkg::*;
#(
  parameter int unsigned DIN_W          = 32,
  parameter int unsigned DOUT_W         = 12,
  parameter int unsigned SLICES_PER_CYC = 1,
  parameter int unsigned ROT            = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DIN_W-1:0]  data_i,
  input  logic [DOUT_W-1:0] seed_i,
  input  logic              mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DOUT_W-1:0] data_o
);

  localparam int unsigned N_SLICES = n_slices(DIN_W, DOUT_W);
  localparam int unsigned N_ITER   = (N_SLICES + SLICES_PER_CYC - 1) / SLICES_PER_CYC;
  localparam int unsigned GRP_W    = SLICES_PER_CYC * DOUT_W;
  localparam int unsigned KEY_W    = N_ITER * GRP_W;
  localparam int unsigned IDX_W    = $clog2(N_ITER * SLICES_PER_CYC + 1);

  hasher_state_e     state_q, state_d;
  hash_mode_e        mode_q;
  logic [KEY_W-1:0]  key_q;
  logic [DOUT_W-1:0] acc_q;
  logic [IDX_W-1:0]  slice_idx_q;
  logic              accept;
  logic              last_grp;
  logic [DOUT_W-1:0] fold_result;

  assign last_grp = (32'(slice_idx_q) + SLICES_PER_CYC) >= N_SLICES;

  // The key register shifts right by one group per fold cycle, so each step
  // always reads a fixed slice position; slice_idx_q only gates the tail group.
  for (genvar g = 0; g < SLICES_PER_CYC; g++) begin : g_step
    localparam int unsigned OFS = g;
    logic [DOUT_W-1:0] acc_in;
    logic [DOUT_W-1:0] acc_out;
    logic              en;

    if (g == 0) begin : g_first
      assign acc_in = acc_q;
    end else begin : g_chain
      assign acc_in = g_step[g-1].acc_out;
    end

    assign en = (32'(slice_idx_q) + OFS) < N_SLICES;

    xor_fold_step #(
      .DOUT_W (DOUT_W),
      .ROT    (ROT)
    ) u_step (
      .acc      (acc_in),
      .slice    (key_q[g*DOUT_W +: DOUT_W]),
      .mode     (mode_q),
      .enable   (en),
      .next_acc (acc_out)
    );
  end

  assign fold_result = g_step[SLICES_PER_CYC-1].acc_out;

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = FOLD;
      end
      FOLD: begin
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_d = in_valid_i ? FOLD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = in_valid_i && in_ready_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      acc_q       <= '0;
      slice_idx_q <= '0;
      mode_q      <= HASH_XOR;
    end else if (accept) begin
      key_q       <= KEY_W'(data_i);
      acc_q       <= seed_i;
      slice_idx_q <= '0;
      mode_q      <= hash_mode_e'(mode_i);
    end else if (state_q == FOLD) begin
      key_q       <= key_q >> GRP_W;
      acc_q       <= fold_result;
      slice_idx_q <= slice_idx_q + IDX_W'(SLICES_PER_CYC);
    end
  end

  assign data_o = acc_q;

endmodule

// File: tb/tb_xor_fold_hasher.sv
// Bench for xor_fold_hasher: one and two slices per cycle driven from a shared source.
module tb_xor_fold_hasher;

  localparam int N_RAND = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] data;
  logic [11:0] seed;
  logic        mode;
  logic        out_ready;
  logic        in_ready1, out_valid1, in_ready2, out_valid2;
  logic [11:0] data_o1, data_o2;

  int total = 0;
  int bad   = 0;

  logic [11:0] q1[$];
  logic [11:0] q2[$];

  typedef struct {
    logic [31:0] key;
    logic [11:0] seed;
    logic        mode;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  xor_fold_hasher #(.DIN_W(32), .DOUT_W(12), .SLICES_PER_CYC(1), .ROT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .data_i(data), .seed_i(seed), .mode_i(mode),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .data_o(data_o1)
  );

  xor_fold_hasher #(.DIN_W(32), .DOUT_W(12), .SLICES_PER_CYC(2), .ROT(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .data_i(data), .seed_i(seed), .mode_i(mode),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .data_o(data_o2)
  );

  function automatic logic [11:0] ref_hash(input logic [31:0] key, input logic [11:0] s,
                                           input logic m);
    logic [35:0] padded;
    logic [11:0] acc;
    padded = {4'h0, key};
    acc    = s;
    for (int k = 0; k < 3; k++) begin
      if (m) acc = {acc[10:0], acc[11]};
      acc = acc ^ padded[k*12 +: 12];
    end
    return acc;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboards: push on each DUT's accept, pop on each DUT's handoff.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) check("dut1_unexpected_out", 32'(data_o1), 32'hFFFF_FFFF);
        else check("dut1_scoreboard", 32'(data_o1), 32'(q1.pop_front()));
      end
      if (in_valid && in_ready1) q1.push_back(ref_hash(data, seed, mode));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) check("dut2_unexpected_out", 32'(data_o2), 32'hFFFF_FFFF);
        else check("dut2_scoreboard", 32'(data_o2), 32'(q2.pop_front()));
      end
      if (in_valid && in_ready2) q2.push_back(ref_hash(data, seed, mode));
    end
  end

  task automatic wait_valid1(output int lat);
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid1) lat = c;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int lat1, lat2;
    check($sformatf("v%0d_idle_ready", idx), 32'(in_ready1 & in_ready2), 32'd1);
    data = v.key; seed = v.seed; mode = v.mode; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data = $urandom; seed = 12'($urandom); mode = ~v.mode;
    lat1 = 0; lat2 = 0;
    for (int c = 1; c <= 10 && (lat1 == 0 || lat2 == 0); c++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = c;
      if (out_valid2 && lat2 == 0) lat2 = c;
    end
    check($sformatf("v%0d_lat_spc1", idx), 32'(lat1), 32'd3);
    check($sformatf("v%0d_lat_spc2", idx), 32'(lat2), 32'd2);
    check($sformatf("v%0d_hash_spc1", idx), 32'(data_o1), 32'(v.exp));
    check($sformatf("v%0d_hash_spc2", idx), 32'(data_o2), 32'(v.exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stale, timeouts, accepted;

    vecs[0] = '{32'hDEADBEEF, 12'h000, 1'b0, 12'h4EA};
    vecs[1] = '{32'hDEADBEEF, 12'h000, 1'b1, 12'hED6};
    vecs[2] = '{32'hDEADBEEF, 12'hFFF, 1'b0, 12'hB15};
    vecs[3] = '{32'hFFFFFFFF, 12'h000, 1'b0, 12'h0FF};
    vecs[4] = '{32'hFFFFFFFF, 12'h000, 1'b1, 12'h0FF};
    vecs[5] = '{32'h00000001, 12'h000, 1'b1, 12'h004};
    vecs[6] = '{32'h80000000, 12'h000, 1'b0, 12'h080};
    vecs[7] = '{32'h00000000, 12'h800, 1'b1, 12'h004};

    rst = 1'b1; in_valid = 1'b0; data = '0; seed = '0; mode = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_data1", 32'(data_o1), 32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    check("rst_data2", 32'(data_o2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready1", 32'(in_ready1), 32'd1);
    check("post_rst_ready2", 32'(in_ready2), 32'd1);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    // Backpressure: result held in DONE while the next key waits on the bus.
    data = 32'hDEADBEEF; seed = 12'h000; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    data = 32'h00000001; seed = 12'h000; mode = 1'b1;
    wait_valid1(lat);
    check("bp_first_lat", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_data_c%0d", c), 32'(data_o1), 32'h4EA);
      check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid1), 32'd1);
      check($sformatf("bp_hold_ready_c%0d", c), 32'(in_ready1 | in_ready2), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_comb_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_valid_drop", 32'(out_valid1), 32'd0);
    check("bp_in_fold", 32'(in_ready1), 32'd0);
    wait_valid1(lat);
    check("bp_second_lat", 32'(lat), 32'd3);
    check("bp_second_hash", 32'(data_o1), 32'h004);
    check("bp_second_hash2", 32'(data_o2), 32'h004);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a fold discards the key.
    data = 32'hCAFEF00D; seed = 12'h5A5; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    q1.delete(); q2.delete();
    #1;
    check("midfold_rst_valid1", 32'(out_valid1), 32'd0);
    check("midfold_rst_data1", 32'(data_o1), 32'd0);
    check("midfold_rst_valid2", 32'(out_valid2), 32'd0);
    check("midfold_rst_data2", 32'(data_o2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midfold_ready", 32'(in_ready1 & in_ready2), 32'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid2) stale++;
    end
    check("no_stale_output", 32'(stale), 32'd0);
    out_ready = 1'b0;
    apply_vec('{32'h00000000, 12'h123, 1'b0, 12'h123}, 8);

    // Random keys, modes, seeds and sink backpressure.
    timeouts = 0;
    for (int t = 0; t < N_RAND; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      data = $urandom; seed = 12'($urandom); mode = 1'($urandom); in_valid = 1'b1;
      accepted = 0;
      for (int g = 0; g < 64 && accepted == 0; g++) begin
        @(negedge clk);
        accepted = int'(in_ready1);
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      if (accepted == 0) timeouts++;
    end
    check("rand_accept_timeouts", 32'(timeouts), 32'd0);

    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && (q1.size() != 0 || q2.size() != 0); c++) begin
      @(posedge clk); #1;
    end
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);
    @(posedge clk); #1;
    check("final_idle1", 32'(in_ready1 & ~out_valid1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
